// File: rtl/vector_output_drain_if.sv
// Bundle between the CPU result port, the drain block and the downstream element sink.
// The slave modport is the drain block's side; the master modport is the CPU/sink side.
interface vector_output_drain_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_SIZE = 6,
  parameter int FIFO_DEPTH  = 4
);
  localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [VEC_W-1:0]      vectorIn;
  logic                  vectorValid;
  logic [DATA_WIDTH-1:0] elementOut;
  logic                  elementValid;
  logic                  elementReady;
  logic [IDX_W-1:0]      elementIndex;
  logic                  lastElement;
  logic [CNT_W-1:0]      fifoCount;
  logic                  overflow;

  modport slave (
    input  vectorIn, vectorValid, elementReady,
    output elementOut, elementValid, elementIndex, lastElement, fifoCount, overflow
  );

  modport master (
    output vectorIn, vectorValid, elementReady,
    input  elementOut, elementValid, elementIndex, lastElement, fifoCount, overflow
  );
endinterface

// File: rtl/vector_output_drain.sv
// Buffers whole CPU result vectors in a small FIFO and streams them out one element per transfer.
// Stream handshake: an element moves when elementValid && elementReady on a rising edge; while
// elementValid is high and elementReady is low, elementOut/elementIndex hold their values.
module vector_output_drain #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_SIZE = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  vector_output_drain_if.slave bus,
  output logic                 dbg_state_o
);
  localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;

  logic [VEC_W-1:0] head;
  logic             full, transfer, pop, push;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: count and pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= bus.vectorIn;
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    full     = (count_q == FULL_CNT);
    transfer = (state_q == SEND) && bus.elementReady;
    pop      = transfer && (idx_q == LAST_IDX);
    // A full FIFO still accepts a vector when the head leaves on the same edge.
    push     = bus.vectorValid && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | (bus.vectorValid && !push);

    idx_d = idx_q;
    if (transfer) begin
      idx_d = pop ? '0 : idx_q + IDX_W'(1);
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (count_d != '0) state_d = SEND;
      SEND:    if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.elementValid = (state_q == SEND);
  assign bus.elementOut   = (state_q == SEND) ? head[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.elementIndex = idx_q;
  assign bus.lastElement  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign bus.fifoCount    = count_q;
  assign bus.overflow     = overflow_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_vector_output_drain.sv
// Directed bench for vector_output_drain: single vector, backpressure, back-to-back,
// overflow, full push+pop and reset mid-drain, all against hand-written vectors.
module tb_vector_output_drain;
  localparam int DW = 16;
  localparam int VS = 6;
  localparam int FD = 4;

  logic clock;
  logic reset;
  logic dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_i[$];

  vector_output_drain_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .FIFO_DEPTH(FD)) bus ();

  vector_output_drain #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .FIFO_DEPTH(FD)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [VS*DW-1:0] v);
    bus.vectorIn    = v;
    bus.vectorValid = 1'b1;
    tick();
    bus.vectorValid = 1'b0;
  endtask

  task automatic expect_vec(input logic [VS*DW-1:0] v);
    for (int k = 0; k < VS; k++) begin
      exp_q.push_back(v[k*DW +: DW]);
      exp_i.push_back(k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.elementValid), 32'd0);
    check({tag, "_out"},   32'(bus.elementOut),   32'd0);
    check({tag, "_idx"},   32'(bus.elementIndex), 32'd0);
    check({tag, "_last"},  32'(bus.lastElement),  32'd0);
    check({tag, "_count"}, 32'(bus.fifoCount),    32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),     32'd0);
    check({tag, "_state"}, 32'(dbg_state),        32'd0);
  endtask

  // Scoreboard: consumes exp_q on every observed transfer.
  task automatic drain(input string tag, input int budget, input bit bp, input bit no_bubble);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      bus.elementReady = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (bus.elementValid) begin
        check({tag, "_elem"}, 32'(bus.elementOut), 32'(exp_q[0]));
        check({tag, "_idx"},  32'(bus.elementIndex), 32'(exp_i[0]));
        check({tag, "_last"}, 32'(bus.lastElement), 32'(exp_i[0] == VS - 1));
        if (bus.elementReady) begin
          void'(exp_q.pop_front());
          void'(exp_i.pop_front());
        end
      end else if (no_bubble) begin
        check({tag, "_bubble"}, 32'(bus.elementValid), 32'd1);
      end
      tick();
      c++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_i.delete();
  endtask

  logic [VS*DW-1:0] v1 = 96'h0006_0005_0004_0003_0002_0001;
  logic [VS*DW-1:0] va = 96'hA005_A004_A003_A002_A001_A000;
  logic [VS*DW-1:0] vb = 96'hB005_B004_B003_B002_B001_B000;
  logic [VS*DW-1:0] vc [5];
  logic [VS*DW-1:0] vd [5];
  logic [VS*DW-1:0] ve0 = 96'hE005_E004_E003_E002_E001_E000;
  logic [VS*DW-1:0] ve1 = 96'hE105_E104_E103_E102_E101_E100;
  logic [VS*DW-1:0] vf  = 96'hF005_F004_F003_F002_F001_F000;

  initial begin
    vc[0] = 96'hC005_C004_C003_C002_C001_C000;
    vc[1] = 96'hC105_C104_C103_C102_C101_C100;
    vc[2] = 96'hC205_C204_C203_C202_C201_C200;
    vc[3] = 96'hC305_C304_C303_C302_C301_C300;
    vc[4] = 96'hC405_C404_C403_C402_C401_C400;
    vd[0] = 96'hD005_D004_D003_D002_D001_D000;
    vd[1] = 96'hD105_D104_D103_D102_D101_D100;
    vd[2] = 96'hD205_D204_D203_D202_D201_D200;
    vd[3] = 96'hD305_D304_D303_D302_D301_D300;
    vd[4] = 96'hD405_D404_D403_D402_D401_D400;

    reset            = 1'b1;
    bus.vectorIn     = '0;
    bus.vectorValid  = 1'b0;
    bus.elementReady = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Single vector, ready held high: element 0 visible the cycle after the push.
    bus.elementReady = 1'b1;
    push(v1);
    for (int k = 0; k < VS; k++) begin
      check("single_valid", 32'(bus.elementValid), 32'd1);
      check("single_out",   32'(bus.elementOut),   32'(k + 1));
      check("single_idx",   32'(bus.elementIndex), 32'(k));
      check("single_last",  32'(bus.lastElement),  32'(k == VS - 1));
      check("single_count", 32'(bus.fifoCount),    32'd1);
      tick();
    end
    check("single_end_valid", 32'(bus.elementValid), 32'd0);
    check("single_end_out",   32'(bus.elementOut),   32'd0);
    check("single_end_count", 32'(bus.fifoCount),    32'd0);
    check("single_end_state", 32'(dbg_state),        32'd0);

    // Backpressure with ready pattern 1,0,0,1.
    bus.elementReady = 1'b0;
    push(v1);
    expect_vec(v1);
    drain("bp", 60, 1'b1, 1'b0);
    check("bp_end_state", 32'(dbg_state), 32'd0);

    // Back-to-back vectors: no bubble between A5 and B0.
    bus.elementReady = 1'b0;
    push(va);
    push(vb);
    check("b2b_count", 32'(bus.fifoCount), 32'd2);
    expect_vec(va);
    expect_vec(vb);
    drain("b2b", 40, 1'b0, 1'b1);
    check("b2b_end_count", 32'(bus.fifoCount), 32'd0);

    // Overflow: fifth vector into a full FIFO is dropped.
    bus.elementReady = 1'b0;
    for (int n = 0; n < 4; n++) push(vc[n]);
    check("ovf_count4", 32'(bus.fifoCount), 32'd4);
    check("ovf_before", 32'(bus.overflow),  32'd0);
    push(vc[4]);
    check("ovf_count5", 32'(bus.fifoCount), 32'd4);
    check("ovf_after",  32'(bus.overflow),  32'd1);
    for (int n = 0; n < 4; n++) expect_vec(vc[n]);
    drain("ovf", 60, 1'b0, 1'b1);
    check("ovf_end_count", 32'(bus.fifoCount), 32'd0);
    check("ovf_sticky",    32'(bus.overflow),  32'd1);
    check("ovf_end_valid", 32'(bus.elementValid), 32'd0);

    // Full FIFO, push on the edge of the last-element transfer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.elementReady = 1'b0;
    for (int n = 0; n < 4; n++) push(vd[n]);
    check("fpp_count_full", 32'(bus.fifoCount), 32'd4);
    bus.elementReady = 1'b1;
    for (int k = 0; k < VS - 1; k++) begin
      check("fpp_head_out", 32'(bus.elementOut), 32'(16'hD000 + k));
      tick();
    end
    check("fpp_idx_last", 32'(bus.elementIndex), 32'd5);
    check("fpp_out_last", 32'(bus.elementOut),   32'h0000D005);
    push(vd[4]);
    check("fpp_count",  32'(bus.fifoCount),    32'd4);
    check("fpp_ovf",    32'(bus.overflow),     32'd0);
    check("fpp_next",   32'(bus.elementOut),   32'h0000D100);
    check("fpp_idx0",   32'(bus.elementIndex), 32'd0);
    for (int n = 1; n < 5; n++) expect_vec(vd[n]);
    drain("fpp", 60, 1'b0, 1'b1);
    check("fpp_end_count", 32'(bus.fifoCount), 32'd0);

    // Reset mid-drain after element 2 of the first of two queued vectors.
    bus.elementReady = 1'b0;
    push(ve0);
    push(ve1);
    bus.elementReady = 1'b1;
    tick();
    tick();
    tick();
    check("rmd_idx3",  32'(bus.elementIndex), 32'd3);
    check("rmd_count", 32'(bus.fifoCount),    32'd2);
    reset = 1'b1;
    tick();
    check_reset_outputs("rmd");
    reset = 1'b0;
    push(vf);
    check("rmd_new_out", 32'(bus.elementOut), 32'h0000F000);
    expect_vec(vf);
    drain("rmd", 30, 1'b0, 1'b1);
    check("rmd_end_count", 32'(bus.fifoCount), 32'd0);
    check("rmd_end_state", 32'(dbg_state),     32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
